// File: rtl/ledr_pwm_blink.sv
// Output stage for the red-LED port: global PWM dimming plus per-LED blinking,
// configured through a small zero-wait-state Avalon-MM slave.
module ledr_pwm_blink #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [17:0] pattern_in,
  output logic [17:0] led_out
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [7:0]    duty_q, duty_d;
  logic [15:0]   half_q, half_d;
  logic [17:0]   mask_q, mask_d;
  logic          en_q, en_d;
  logic          phase_q, phase_d;
  logic [15:0]   blink_cnt_q, blink_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [17:0]   led_q, led_d;

  logic wr;
  logic tick;
  logic pwm_on;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:18];

  always_comb begin
    wr          = chipselect & ~write_n;
    duty_d      = duty_q;
    half_d      = half_q;
    mask_d      = mask_q;
    en_d        = en_q;
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;
    pwm_cnt_d   = pwm_cnt_q + 8'd1;
    tick        = (presc_q == PRESC_MAX);
    presc_d     = tick ? '0 : presc_q + PW'(1);

    // HALF==0 disables blinking: phase pinned on, counter parked at zero.
    if (half_q == 16'd0) begin
      blink_cnt_d = 16'd0;
      phase_d     = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == half_q - 16'd1) begin
        blink_cnt_d = 16'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    // Register writes override any tick landing in the same cycle.
    if (wr) begin
      case (address)
        2'd0: duty_d = writedata[7:0];
        2'd1: begin
          half_d      = writedata[15:0];
          blink_cnt_d = 16'd0;
          presc_d     = '0;
          phase_d     = phase_q;
        end
        2'd2: mask_d = writedata[17:0];
        default: begin
          en_d = writedata[0];
          if (writedata[2]) begin
            phase_d     = 1'b1;
            blink_cnt_d = 16'd0;
            presc_d     = '0;
          end
        end
      endcase
    end

    pwm_on = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);
    led_d  = pattern_in & {18{en_q & pwm_on}} & (~mask_q | {18{phase_q}});
  end

  always_comb begin
    case (address)
      2'd0:    readdata = {24'd0, duty_q};
      2'd1:    readdata = {16'd0, half_q};
      2'd2:    readdata = {14'd0, mask_q};
      default: readdata = {30'd0, phase_q, en_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q      <= 8'hFF;
      half_q      <= 16'd250;
      mask_q      <= 18'd0;
      en_q        <= 1'b1;
      phase_q     <= 1'b1;
      blink_cnt_q <= 16'd0;
      presc_q     <= '0;
      pwm_cnt_q   <= 8'd0;
      led_q       <= 18'd0;
    end else begin
      duty_q      <= duty_d;
      half_q      <= half_d;
      mask_q      <= mask_d;
      en_q        <= en_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_q       <= led_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: doc/ledr_pwm_blink.md
Name: ledr_pwm_blink

Overview:
- Output-side stage between the 18-bit red-LED parallel output port and the LEDR[17:0] pins.
- Takes the port's pattern word and applies global PWM dimming and per-LED blinking, then drives the pins.
- Has its own small Avalon-MM slave (4 registers, zero read wait states) on the same system bus, so software sets brightness and blink without rewriting the pattern.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- TICK_HZ, 1000: blink time-base tick rate. Default is a 1 ms tick. Prescale = CLK_HZ/TICK_HZ, which must be at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect && !write_n.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero-extended.
- pattern_in  in  18  LED pattern from the upstream output port; 1 = LED lit.
- led_out  out  18  registered drive to LEDR pins.

Behaviour:
- Register map (read value / write effect / reset value):
  - addr0 DUTY[7:0]: brightness; reset 255.
  - addr1 HALF[15:0]: blink half-period in ticks; reset 250. Any write also clears blink_cnt and prescaler.
  - addr2 MASK[17:0]: LEDs subject to blinking; reset 0.
  - addr3 CTRL: bit0 EN (RW, reset 1); bit1 PHASE (RO); bit2 RESTART (write-only, reads 0).
    - Writing bit2=1 sets PHASE=1 and clears blink_cnt and prescaler.
- Reads:
  - readdata is combinational from address, valid in the same cycle, with zero read latency.
  - Unused bits read 0. chipselect is not required for reads.
- PWM:
  - pwm_cnt is 8 bits, free-running, +1 every clk, wraps 255->0. Period is 256 clocks.
  - pwm_on = (DUTY==255) | (pwm_cnt < DUTY).
  - DUTY=0 means always off. DUTY=255 means always on, with no one-cycle gap.
- Tick prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1.
  - tick is a one-clock pulse in the cycle the count wraps to 0.
- Blink:
  - blink_cnt is 16 bits.
  - On tick, if HALF != 0: when blink_cnt == HALF-1, set blink_cnt = 0 and toggle PHASE; otherwise blink_cnt += 1.
  - HALF == 0: PHASE is forced to 1 and blink_cnt is held at 0 (blinking disabled).
  - Reset: PHASE = 1, blink_cnt = 0, prescaler = 0, pwm_cnt = 0.
- Output, registered:
  - led_out[i] <= EN & pattern_in[i] & pwm_on & (~MASK[i] | PHASE).
  - pattern_in to led_out latency is 1 clk. Register writes take effect on led_out 2 clks after the write edge.
  - led_out resets to 0 and is 0 throughout reset.
- Simultaneous events:
  - A RESTART or HALF write in the same cycle as a tick wins: counters clear and PHASE is set to 1 (RESTART) or left unchanged (HALF); the tick is discarded.
  - Writing HALF smaller than the current blink_cnt is safe because the counter is cleared on the write.
- Reset mid-operation: all registers return to their reset values asynchronously. Operation resumes from a clean phase-on state.
- pattern_in is synchronous to clk (it comes from the upstream port); no synchronizer.

Test Plan:
- Bench setup: CLK_HZ=1000, TICK_HZ=100 (tick every 10 clk).
- Reset defaults: hold reset_n=0 with pattern_in=18'h3FFFF.
  - Required: led_out=0 during reset.
  - After release: led_out=18'h3FFFF from the 2nd clk onward.
  - Reads: addr0=255, addr1=250, addr2=0, addr3=0x3.
- PWM duty: write DUTY=64, pattern_in=18'h00001.
  - Required: led_out[0] high exactly 64 of every 256 clks.
  - DUTY=0: never high. DUTY=255: continuously high.
- Blink: write HALF=3, MASK=18'h00002, RESTART, pattern_in=18'h00003.
  - Required: led_out[1] toggles every 30 clks, starting on.
  - led_out[0] stays steady on.
  - CTRL bit1 tracks the phase.
- Blink edges:
  - HALF=0: led_out[1] constantly on.
  - RESTART issued during the off phase: led_out[1] on 2 clks later, and the next toggle comes 30 clks later.
  - RESTART coincident with a tick: the tick is ignored.
- Enable and latency:
  - Write CTRL=0: led_out=0 within 2 clks.
  - Re-enable with CTRL=1: restored.
  - Change pattern_in 18'h0F0F0 -> 18'h00F0F: led_out follows 1 clk later.
- Reset mid-blink: assert reset_n=0 for 1 clk while PHASE=0 and DUTY=10.
  - Required: immediate led_out=0.
  - After reset: DUTY=255, MASK=0, PHASE=1.
